// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP transmit path: payload length width and the
// packetizer read-side state encoding.
package udp_tx_pkg;

  localparam int unsigned LEN_W               = 12;
  localparam int unsigned DEFAULT_MAX_PAYLOAD = 1472;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } rd_state_e;

endpackage

// File: rtl/sdp_byte_ram.sv
// Simple dual-port byte RAM: one write port, one read port with a registered
// output (1-cycle read latency). No reset so it maps onto block RAM.
module sdp_byte_ram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_payload_packetizer.sv
// Store-and-forward packetizer: buffers user bytes into closed frames and
// replays each one with its byte count on TUSER from the first beat.
module udp_payload_packetizer
  import udp_tx_pkg::*;
#(
  parameter int unsigned DATA_AW     = 11,
  parameter int unsigned LEN_AW      = 3,
  parameter int unsigned MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [7:0]       M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  output logic [LEN_W-1:0] M_AXIS_TUSER,
  input  logic             M_AXIS_TREADY,
  output logic [15:0]      FRAME_COUNT
);

  localparam int unsigned        IdleW     = $clog2(TIMEOUT + 2);
  localparam logic [IdleW-1:0]   IdleMax   = IdleW'(TIMEOUT);
  localparam logic [LEN_W-1:0]   MaxLen    = LEN_W'(MAX_PAYLOAD);
  localparam logic [DATA_AW:0]   DataDepth = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [LEN_AW:0]    LenDepth  = {1'b1, {LEN_AW{1'b0}}};

  // Write side state
  logic [DATA_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_AW:0]   data_cnt_q, data_cnt_d;
  logic               data_full_q, data_full_d;
  logic               s_ready_q, s_ready_d;
  logic [LEN_W-1:0]   wr_len_q, wr_len_d, wr_len_inc;
  logic [IdleW-1:0]   idle_q, idle_d, idle_inc;

  // Length FIFO
  logic [LEN_W-1:0]   len_mem [2**LEN_AW];
  logic [LEN_AW-1:0]  len_wr_ptr_q, len_wr_ptr_d, len_rd_ptr_q, len_rd_ptr_d;
  logic [LEN_AW:0]    len_cnt_q, len_cnt_d;
  logic               len_full_q, len_full_d;
  logic               len_empty_q, len_empty_d;

  // Read side state
  rd_state_e          state_q, state_d;
  logic [DATA_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               accept, push, pop, m_valid, m_hs, last_beat;
  logic [LEN_W-1:0]   push_len;
  logic [7:0]         ram_rdata;

  assign accept   = S_AXIS_TVALID && s_ready_q;
  assign m_valid  = (state_q == SEND);
  assign m_hs     = m_valid && M_AXIS_TREADY;
  assign last_beat = (rd_cnt_q == len_q - 1'b1);

  // Frame closing: TLAST, reaching MAX_PAYLOAD, or an idle timeout.
  always_comb begin
    wr_len_inc = wr_len_q + 1'b1;
    idle_inc   = idle_q + 1'b1;
    wr_len_d   = wr_len_q;
    idle_d     = idle_q;
    push       = 1'b0;
    push_len   = wr_len_inc;
    if (accept) begin
      idle_d = '0;
      if (S_AXIS_TLAST || (wr_len_inc == MaxLen)) begin
        push     = 1'b1;
        wr_len_d = '0;
      end else begin
        wr_len_d = wr_len_inc;
      end
    end else if ((wr_len_q != '0) && (TIMEOUT != 0)) begin
      if (idle_inc >= IdleMax) begin
        // Hold at the limit until the length FIFO has room.
        if (!len_full_q) begin
          push     = 1'b1;
          push_len = wr_len_q;
          wr_len_d = '0;
          idle_d   = '0;
        end else begin
          idle_d = IdleMax;
        end
      end else begin
        idle_d = idle_inc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!len_empty_q) begin
          pop      = 1'b1;
          len_d    = len_mem[len_rd_ptr_q];
          rd_cnt_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        if (m_hs) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (last_beat) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    len_wr_ptr_d = push ? len_wr_ptr_q + 1'b1 : len_wr_ptr_q;
    len_rd_ptr_d = pop ? len_rd_ptr_q + 1'b1 : len_rd_ptr_q;
    case ({accept, m_hs})
      2'b10:   data_cnt_d = data_cnt_q + 1'b1;
      2'b01:   data_cnt_d = data_cnt_q - 1'b1;
      default: data_cnt_d = data_cnt_q;
    endcase
    case ({push, pop})
      2'b10:   len_cnt_d = len_cnt_q + 1'b1;
      2'b01:   len_cnt_d = len_cnt_q - 1'b1;
      default: len_cnt_d = len_cnt_q;
    endcase
    data_full_d = (data_cnt_d == DataDepth);
    len_full_d  = (len_cnt_d == LenDepth);
    s_ready_d   = !data_full_d && !len_full_d;
    // Empty flag lags the count by a cycle; this sets the close-to-TVALID latency.
    len_empty_d = (len_cnt_q == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      data_cnt_q   <= '0;
      data_full_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      wr_len_q     <= '0;
      idle_q       <= '0;
      len_wr_ptr_q <= '0;
      len_rd_ptr_q <= '0;
      len_cnt_q    <= '0;
      len_full_q   <= 1'b0;
      len_empty_q  <= 1'b1;
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      frame_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      data_cnt_q   <= data_cnt_d;
      data_full_q  <= data_full_d;
      s_ready_q    <= s_ready_d;
      wr_len_q     <= wr_len_d;
      idle_q       <= idle_d;
      len_wr_ptr_q <= len_wr_ptr_d;
      len_rd_ptr_q <= len_rd_ptr_d;
      len_cnt_q    <= len_cnt_d;
      len_full_q   <= len_full_d;
      len_empty_q  <= len_empty_d;
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      len_mem[len_wr_ptr_q] <= push_len;
    end
  end

  // Reading at rd_ptr_d prefetches the next byte on a handshake and re-reads
  // the current one while stalled, so TDATA stays put.
  sdp_byte_ram #(
    .AW (DATA_AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (S_AXIS_TDATA),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = m_valid ? ram_rdata : 8'h00;
  assign M_AXIS_TUSER  = m_valid ? len_q : '0;
  assign M_AXIS_TLAST  = m_valid && last_beat;
  assign FRAME_COUNT   = frame_cnt_q;

endmodule

// File: tb/tb_udp_payload_packetizer.sv
// Bench for udp_payload_packetizer: vector table, directed corner sequences and
// random traffic, all checked against a frame/byte queue model.
module tb_udp_payload_packetizer;

  localparam int unsigned MaxPay = 1472;
  localparam int unsigned Tmo    = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [11:0] m_tuser;
  logic        m_tready = 1'b0;
  logic [15:0] frame_count;

  always #5 CLK = ~CLK;

  udp_payload_packetizer #(
    .DATA_AW     (11),
    .LEN_AW      (3),
    .MAX_PAYLOAD (MaxPay),
    .TIMEOUT     (Tmo)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TREADY (m_tready),
    .FRAME_COUNT   (frame_count)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Output ready: either a commanded level or a 50% random stall pattern.
  logic rand_mode = 1'b0;
  logic ready_cmd = 1'b0;
  always @(posedge CLK) begin
    #1;
    m_tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Monitor: collects emitted frames and checks AXIS hold rules.
  byte unsigned rx_data[$];
  int           rx_len[$];
  int           rx_user[$];
  int           beat_cnt = 0;
  int unsigned  rise_cyc = 0;
  logic         prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  logic [11:0]  prev_user = 12'h0, frame_user = 12'h0;

  always @(negedge CLK) begin
    if (RST) begin
      beat_cnt   = 0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, prev_data);
        check("stall_user", m_tuser, prev_user);
        check("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && !prev_valid) begin
        rise_cyc   = cyc;
        frame_user = m_tuser;
      end
      if (m_tvalid && m_tready) begin
        check("tuser_const", m_tuser, frame_user);
        rx_data.push_back(m_tdata);
        beat_cnt++;
        if (m_tlast) begin
          check("tlast_pos", beat_cnt, m_tuser);
          rx_len.push_back(beat_cnt);
          rx_user.push_back(int'(m_tuser));
          beat_cnt = 0;
        end
      end
      prev_valid = m_tvalid;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_user  = m_tuser;
      prev_last  = m_tlast;
    end
  end

  // Reference model: accepted bytes in order, and frame lengths by the close rules.
  byte unsigned exp_data[$];
  int           exp_len[$];
  int           open_cnt = 0;
  int           fc_base = 0;
  int unsigned  acc_cyc = 0;

  task automatic send_byte(input logic [7:0] d, input logic l);
    int g = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    @(negedge CLK);
    while (!s_tready && g < 20000) begin
      @(negedge CLK);
      g++;
    end
    if (!s_tready) begin
      check("s_tready_wait", s_tready, 1);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    exp_data.push_back(d);
    open_cnt++;
    if (l || open_cnt == int'(MaxPay)) begin
      exp_len.push_back(open_cnt);
      open_cnt = 0;
    end
  endtask

  // Called once the write side has been left idle well past the timeout.
  task automatic model_timeout();
    if (open_cnt > 0) begin
      exp_len.push_back(open_cnt);
      open_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int g = 0;
    while (rx_len.size() < n && g < 20000) begin
      @(negedge CLK);
      g++;
    end
    check("frames_arrived", rx_len.size(), n);
  endtask

  task automatic compare_all();
    int n;
    check("frame_total", rx_len.size(), exp_len.size());
    n = (rx_len.size() < exp_len.size()) ? rx_len.size() : exp_len.size();
    for (int i = 0; i < n; i++) check("frame_len", rx_len[i], exp_len[i]);
    check("byte_total", rx_data.size(), exp_data.size());
    n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      if (rx_data[i] != exp_data[i]) check("byte_data", rx_data[i], exp_data[i]);
      else total++;
    end
    check("frame_count", frame_count, (fc_base + rx_len.size()) % 65536);
    fc_base += rx_len.size();
    rx_data.delete();
    rx_len.delete();
    rx_user.delete();
    exp_data.delete();
    exp_len.delete();
  endtask

  typedef struct {
    int unsigned n;
    logic        last;
    logic [7:0]  base;
    int unsigned frames;
    int unsigned last_len;
    int unsigned lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nb;
    int sum;
    int g;
    tbl[0] = '{5, 1'b1, 8'h01, 1, 5, 3};
    tbl[1] = '{1, 1'b1, 8'h40, 1, 1, 3};
    tbl[2] = '{2, 1'b1, 8'h50, 1, 2, 3};
    tbl[3] = '{1472, 1'b1, 8'h10, 1, 1472, 3};
    tbl[4] = '{1473, 1'b1, 8'h20, 2, 1, 0};
    tbl[5] = '{3, 1'b0, 8'h30, 1, 3, Tmo + 3};

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_frame_count", frame_count, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    ready_cmd = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("s_tready_after_rst", s_tready, 1);
    idle(2);

    for (int i = 0; i < 6; i++) begin
      nb = rx_len.size();
      for (int j = 0; j < int'(tbl[i].n); j++)
        send_byte(tbl[i].base + 8'(j), tbl[i].last && (j == int'(tbl[i].n) - 1));
      if (!tbl[i].last) model_timeout();
      wait_frames(nb + int'(tbl[i].frames));
      idle(8);
      check("vec_frames", rx_len.size() - nb, tbl[i].frames);
      if (rx_len.size() > 0) check("vec_len", rx_len[rx_len.size() - 1], tbl[i].last_len);
      if (tbl[i].lat != 0) check("vec_latency", rise_cyc - acc_cyc, tbl[i].lat);
      check("vec_frame_count", frame_count, (fc_base + rx_len.size()) % 65536);
    end
    compare_all();

    // Long stream without TLAST: two forced closes then a timeout close.
    for (int j = 0; j < 3000; j++) send_byte(8'(j * 7), 1'b0);
    model_timeout();
    wait_frames(3);
    idle(4);
    if (rx_len.size() >= 3) begin
      check("stream_len0", rx_len[0], 1472);
      check("stream_len1", rx_len[1], 1472);
      check("stream_len2", rx_len[2], 56);
    end
    compare_all();

    // Length FIFO fill: one frame sits in the read side, eight more fill the FIFO.
    ready_cmd = 1'b0;
    idle(3);
    for (int k = 0; k < 9; k++) send_byte(8'(k + 100), 1'b1);
    @(negedge CLK);
    check("len_fifo_full_ready", s_tready, 0);
    ready_cmd = 1'b1;
    wait_frames(9);
    for (int k = 0; k < rx_user.size(); k++) check("drain_tuser", rx_user[k], 1);
    idle(3);
    check("ready_after_drain", s_tready, 1);
    compare_all();

    // Random traffic with random output stalls.
    rand_mode = 1'b1;
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_byte(8'($urandom), (j == 1999) || ($urandom_range(0, 63) == 0));
    end
    wait_frames(exp_len.size());
    sum = 0;
    foreach (rx_user[k]) sum += rx_user[k];
    check("tuser_sum", sum, 2000);
    rand_mode = 1'b0;
    idle(3);
    compare_all();

    // Reset while byte 200 of a 400-byte frame is on the bus.
    for (int j = 0; j < 400; j++) send_byte(8'(j), j == 399);
    g = 0;
    while (beat_cnt < 199 && g < 3000) begin
      @(posedge CLK);
      #1;
      g++;
    end
    check("mid_frame_reached", beat_cnt >= 199, 1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tuser", m_tuser, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_frame_count", frame_count, 0);
    rx_data.delete();
    rx_len.delete();
    rx_user.delete();
    exp_data.delete();
    exp_len.delete();
    open_cnt = 0;
    fc_base  = 0;
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(2);
    for (int j = 0; j < 4; j++) send_byte(8'hA0 + 8'(j), j == 3);
    wait_frames(1);
    if (rx_user.size() > 0) check("post_rst_tuser", rx_user[0], 4);
    idle(4);
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
